vend_credit_comparator: RTL and testbench

Parametrised credit accumulator and price comparator for the vending machine datapath. It grows the single-shot 4-bit A >= B compare into a WIDTH-bit sequential block with four jobs: accumulate coin credit, latch the selected product price, fire a dispense when credit >= price, and return change or a refund. It sits between the coin-acceptor front end and the dispense/change-return drivers.

---
 rtl/vend_credit_comparator_if.sv | 30 +++
 rtl/vend_credit_comparator.sv | 124 ++++++++++++
 tb/tb_vend_credit_comparator.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vend_credit_comparator_if.sv
// Coin, selection and payout signals between the coin acceptor front end,
// the credit comparator and the dispense/change drivers.
interface vend_credit_comparator_if #(
    parameter int WIDTH = 8
);
    logic             coin_valid;
    logic [WIDTH-1:0] coin_value;
    logic             sel_valid;
    logic [WIDTH-1:0] price;
    logic             cancel;
    logic [WIDTH-1:0] credit;
    logic             credit_gte_price;
    logic             dispense;
    logic             change_valid;
    logic [WIDTH-1:0] change_value;
    logic             coin_reject;
    logic             busy;

    modport master (
        output coin_valid, coin_value, sel_valid, price, cancel,
        input  credit, credit_gte_price, dispense, change_valid,
               change_value, coin_reject, busy
    );

    modport slave (
        input  coin_valid, coin_value, sel_valid, price, cancel,
        output credit, credit_gte_price, dispense, change_valid,
               change_value, coin_reject, busy
    );
endinterface

// File: rtl/vend_credit_comparator.sv
// Credit accumulator and price comparator: collects coins, latches a price,
// dispenses when credit covers it and returns change or a refund.
module vend_credit_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vend_credit_comparator_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] credit_reg, credit_next;
    logic [WIDTH-1:0] price_reg, price_next;
    logic             price_valid_reg, price_valid_next;
    logic [WIDTH-1:0] change_value_reg, change_value_next;
    logic             gte_reg, dispense_reg, change_valid_reg, coin_reject_reg, busy_reg;
    logic             dispense_next, change_valid_next, coin_reject_next;
    logic [WIDTH:0]   coin_sum;
    logic             dispense_ready;

    assign coin_sum       = {1'b0, credit_reg} + {1'b0, bus.coin_value};
    assign dispense_ready = price_valid_reg && (credit_reg >= price_reg);

    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        price_next        = price_reg;
        price_valid_next  = price_valid_reg;
        change_value_next = change_value_reg;
        dispense_next     = 1'b0;
        change_valid_next = 1'b0;
        coin_reject_next  = 1'b0;
        case (state_reg)
            IDLE, COLLECT: begin
                if (state_reg == COLLECT && bus.cancel) begin
                    coin_reject_next = bus.coin_valid;
                    if (credit_reg != '0) begin
                        change_value_next = credit_reg;
                        change_valid_next = 1'b1;
                        state_next        = CHANGE;
                    end else begin
                        state_next       = IDLE;
                        price_next       = '0;
                        price_valid_next = 1'b0;
                    end
                end else if (state_reg == COLLECT && dispense_ready) begin
                    // Purchase already committed: freeze credit and price for the payout.
                    coin_reject_next = bus.coin_valid;
                    dispense_next    = 1'b1;
                    state_next       = DISPENSE;
                end else begin
                    if (bus.coin_valid) begin
                        if (!coin_sum[WIDTH]) begin
                            credit_next = coin_sum[WIDTH-1:0];
                            state_next  = COLLECT;
                        end else begin
                            coin_reject_next = 1'b1;
                        end
                    end
                    if (bus.sel_valid) begin
                        price_next       = bus.price;
                        price_valid_next = 1'b1;
                        state_next       = COLLECT;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_next  = bus.coin_valid;
                change_value_next = credit_reg - price_reg;
                if (credit_reg != price_reg) begin
                    change_valid_next = 1'b1;
                    state_next        = CHANGE;
                end else begin
                    state_next       = IDLE;
                    credit_next      = '0;
                    price_next       = '0;
                    price_valid_next = 1'b0;
                end
            end
            default: begin
                coin_reject_next = bus.coin_valid;
                state_next       = IDLE;
                credit_next      = '0;
                price_next       = '0;
                price_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            credit_reg       <= '0;
            price_reg        <= '0;
            price_valid_reg  <= 1'b0;
            change_value_reg <= '0;
            gte_reg          <= 1'b0;
            dispense_reg     <= 1'b0;
            change_valid_reg <= 1'b0;
            coin_reject_reg  <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            price_reg        <= price_next;
            price_valid_reg  <= price_valid_next;
            change_value_reg <= change_value_next;
            gte_reg          <= price_valid_next && (credit_next >= price_next);
            dispense_reg     <= dispense_next;
            change_valid_reg <= change_valid_next;
            coin_reject_reg  <= coin_reject_next;
            busy_reg         <= (state_next == DISPENSE) || (state_next == CHANGE);
        end
    end

    assign bus.credit           = credit_reg;
    assign bus.credit_gte_price = gte_reg;
    assign bus.dispense         = dispense_reg;
    assign bus.change_valid     = change_valid_reg;
    assign bus.change_value     = change_value_reg;
    assign bus.coin_reject      = coin_reject_reg;
    assign bus.busy             = busy_reg;
endmodule

// File: tb/tb_vend_credit_comparator.sv
// Directed bench for vend_credit_comparator: payout pulses are checked
// against a queue of expected events, levels are checked at fixed cycles.
module tb_vend_credit_comparator;
    localparam int WIDTH = 8;
    localparam int EV_DISPENSE = 0;
    localparam int EV_CHANGE   = 1;
    localparam int EV_REJECT   = 2;

    typedef struct {
        int kind;
        int value;
    } event_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     checks = 0;
    int     errors = 0;
    event_t exp_q[$];

    vend_credit_comparator_if #(.WIDTH(WIDTH)) bus ();

    vend_credit_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_event(input int kind, input int value);
        event_t e;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind, input int value);
        event_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pulse observed_kind=%0d expected=none t=%0t", kind, $time);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_value", value, e.value);
        end
    endtask

    // Pulses are sampled mid-cycle and matched against the scoreboard in a fixed order.
    always @(negedge clk) begin
        if (bus.dispense)     check_event(EV_DISPENSE, 0);
        if (bus.change_valid) check_event(EV_CHANGE, int'(bus.change_value));
        if (bus.coin_reject)  check_event(EV_REJECT, 0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic cv, input int cval, input logic sv, input int pval, input logic cn);
        bus.coin_valid = cv;
        bus.coin_value = WIDTH'(cval);
        bus.sel_valid  = sv;
        bus.price      = WIDTH'(pval);
        bus.cancel     = cn;
        step(1);
        bus.coin_valid = 1'b0;
        bus.sel_valid  = 1'b0;
        bus.cancel     = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_credit"}, int'(bus.credit), 0);
        chk({tag, "_gte"}, int'(bus.credit_gte_price), 0);
        chk({tag, "_dispense"}, int'(bus.dispense), 0);
        chk({tag, "_change_valid"}, int'(bus.change_valid), 0);
        chk({tag, "_change_value"}, int'(bus.change_value), 0);
        chk({tag, "_coin_reject"}, int'(bus.coin_reject), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        bus.coin_valid = 1'b0;
        bus.coin_value = '0;
        bus.sel_valid  = 1'b0;
        bus.price      = '0;
        bus.cancel     = 1'b0;
        step(2);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step(1);

        // Exact credit, no change
        strobe(1'b0, 0, 1'b1, 9, 1'b0);
        chk("t1_gte_after_sel", int'(bus.credit_gte_price), 0);
        strobe(1'b1, 5, 1'b0, 0, 1'b0);
        chk("t1_credit5", int'(bus.credit), 5);
        chk("t1_gte5", int'(bus.credit_gte_price), 0);
        expect_event(EV_DISPENSE, 0);
        strobe(1'b1, 4, 1'b0, 0, 1'b0);
        chk("t1_credit9", int'(bus.credit), 9);
        chk("t1_gte9", int'(bus.credit_gte_price), 1);
        chk("t1_busy_k1", int'(bus.busy), 0);
        step(1);
        chk("t1_dispense_k2", int'(bus.dispense), 1);
        chk("t1_busy_k2", int'(bus.busy), 1);
        step(1);
        chk("t1_busy_k3", int'(bus.busy), 0);
        chk("t1_credit_cleared", int'(bus.credit), 0);
        $display("txn exact_credit price=9 coins=5,4 credit=%0d", bus.credit);

        // Change returned
        strobe(1'b0, 0, 1'b1, 5, 1'b0);
        expect_event(EV_DISPENSE, 0);
        expect_event(EV_CHANGE, 4);
        strobe(1'b1, 9, 1'b0, 0, 1'b0);
        chk("t2_credit9", int'(bus.credit), 9);
        step(1);
        chk("t2_dispense_k2", int'(bus.dispense), 1);
        step(1);
        chk("t2_change_valid_k3", int'(bus.change_valid), 1);
        chk("t2_change_value", int'(bus.change_value), 4);
        chk("t2_busy_k3", int'(bus.busy), 1);
        step(1);
        chk("t2_busy_k4", int'(bus.busy), 0);
        chk("t2_credit_cleared", int'(bus.credit), 0);
        $display("txn change price=5 coin=9 change=%0d", bus.change_value);

        // Equality, selection and coin in the same cycle
        expect_event(EV_DISPENSE, 0);
        strobe(1'b1, 7, 1'b1, 7, 1'b0);
        chk("t3_credit7", int'(bus.credit), 7);
        chk("t3_gte", int'(bus.credit_gte_price), 1);
        step(2);
        chk("t3_busy_done", int'(bus.busy), 0);
        $display("txn equal price=7 coin=7");

        // Under price, then cancel with a simultaneous coin
        strobe(1'b1, 2, 1'b1, 3, 1'b0);
        chk("t4_credit2", int'(bus.credit), 2);
        chk("t4_gte", int'(bus.credit_gte_price), 0);
        step(1);
        chk("t4_no_busy", int'(bus.busy), 0);
        expect_event(EV_CHANGE, 2);
        expect_event(EV_REJECT, 0);
        strobe(1'b1, 1, 1'b0, 0, 1'b1);
        chk("t4_refund_valid", int'(bus.change_valid), 1);
        chk("t4_refund_value", int'(bus.change_value), 2);
        chk("t4_cancel_reject", int'(bus.coin_reject), 1);
        step(1);
        chk("t4_credit_cleared", int'(bus.credit), 0);
        $display("txn cancel credit=2 refund=2");

        // Overflow rejection
        strobe(1'b1, 250, 1'b0, 0, 1'b0);
        chk("t5_credit250", int'(bus.credit), 250);
        expect_event(EV_REJECT, 0);
        strobe(1'b1, 10, 1'b0, 0, 1'b0);
        chk("t5_overflow_reject", int'(bus.coin_reject), 1);
        chk("t5_credit_kept", int'(bus.credit), 250);
        expect_event(EV_CHANGE, 250);
        strobe(1'b0, 0, 1'b0, 0, 1'b1);
        step(1);
        chk("t5_credit_cleared", int'(bus.credit), 0);
        $display("txn overflow credit=250 coin=10 rejected");

        // Coin while dispensing
        expect_event(EV_DISPENSE, 0);
        strobe(1'b1, 6, 1'b1, 4, 1'b0);
        step(1);
        expect_event(EV_CHANGE, 2);
        expect_event(EV_REJECT, 0);
        strobe(1'b1, 3, 1'b0, 0, 1'b0);
        chk("t6_busy_reject", int'(bus.coin_reject), 1);
        chk("t6_credit_kept", int'(bus.credit), 6);
        chk("t6_change_value", int'(bus.change_value), 2);
        step(1);
        chk("t6_idle", int'(bus.busy), 0);
        $display("txn busy_coin price=4 coin=6 change=2");

        // Price zero returns all credit
        expect_event(EV_DISPENSE, 0);
        expect_event(EV_CHANGE, 3);
        strobe(1'b1, 3, 1'b1, 0, 1'b0);
        step(3);
        chk("t7_idle", int'(bus.busy), 0);
        $display("txn price_zero coin=3");

        // Reset during DISPENSE
        strobe(1'b1, 5, 1'b1, 2, 1'b0);
        step(1);
        chk("t8_dispense_before_reset", int'(bus.dispense), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t8_in_reset");
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("t8_credit_after", int'(bus.credit), 0);
        $display("txn reset_mid_dispense");

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
